// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types and key-bus constants for the intersection phase scheduler.
// Direction indices double as bit positions in the req/ped_req/grant vectors.
package intersection_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_GREEN  = 3'd1,
    PH_YELLOW = 3'd2,
    PH_ALLRED = 3'd3,
    PH_EMERG  = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_W = 2'd1,
    DIR_E = 2'd2,
    DIR_S = 2'd3
  } dir_e;

  // Indexed by direction: N, W, E, S
  localparam logic [9:0] KEY_GRN  [4] = '{10'h002, 10'h080, 10'h008, 10'h200};
  localparam logic [9:0] KEY_WALK [4] = '{10'h001, 10'h010, 10'h040, 10'h100};

  function automatic logic [3:0] dirOneHot(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_rr_arbiter4.sv
// Four-way round-robin pick: first set candidate bit after the pointer,
// wrapping around, with the pointer's own direction searched last.
module rr_arbiter4
  import intersection_pkg::*;
(
  input  logic [3:0] i_cand,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_win,
  output logic       o_any
);

  // Walk from farthest to nearest so the nearest hit is the last write
  always_comb begin
    o_win = i_ptr + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      if (i_cand[i_ptr + 2'(k)]) begin
        o_win = i_ptr + 2'(k);
      end
    end
  end

  assign o_any = |i_cand;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin green/yellow/all-red scheduler for a four-way intersection,
// driving the datapath key bus with a one-cycle strobe and emergency pre-empt.
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 16,
  parameter int TW         = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_req,
  input  logic [3:0]  i_ped_req,
  input  logic        i_emerg,
  input  logic [1:0]  i_emerg_dir,
  output logic [9:0]  o_key_out,
  output logic        o_key_stb,
  output logic [2:0]  o_phase,
  output logic [3:0]  o_grant,
  output logic        o_all_red,
  output logic [3:0]  o_ped_pend
);

  localparam int GREEN_WALK_CYC = (WALK_CYC > GREEN_CYC) ? WALK_CYC : GREEN_CYC;

  localparam logic [TW-1:0] GREEN_LOAD      = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] GREEN_WALK_LOAD = TW'(GREEN_WALK_CYC - 1);
  localparam logic [TW-1:0] YELLOW_LOAD     = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] ALLRED_LOAD     = TW'(ALLRED_CYC - 1);

  phase_e        r_state;
  phase_e        w_nextState;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_nextTimer;
  logic [1:0]    r_ptr;
  logic [1:0]    w_nextPtr;
  logic [1:0]    r_servedDir;
  logic [1:0]    w_nextDir;
  logic [3:0]    r_pedPend;
  logic [3:0]    w_nextPedPend;
  logic [3:0]    w_pedSeen;
  logic [3:0]    w_cand;
  logic [1:0]    w_win;
  logic          w_any;
  logic          w_timerDone;
  logic          w_enterGreen;
  logic          w_enterEmerg;
  logic [9:0]    w_nextKeyOut;
  logic          w_nextKeyStb;
  logic [3:0]    w_nextGrant;
  logic          w_nextAllRed;

  assign w_cand      = i_req | r_pedPend;
  assign w_pedSeen   = r_pedPend | i_ped_req;
  assign w_timerDone = (r_timer == '0);

  rr_arbiter4 u_arbiter (
    .i_cand (w_cand),
    .i_ptr  (r_ptr),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  always_comb begin
    w_nextState   = r_state;
    w_nextTimer   = w_timerDone ? '0 : r_timer - TW'(1);
    w_nextPtr     = r_ptr;
    w_nextDir     = r_servedDir;
    w_nextPedPend = w_pedSeen;
    w_nextKeyOut  = '0;
    w_nextKeyStb  = 1'b0;
    w_enterGreen  = 1'b0;
    w_enterEmerg  = 1'b0;

    unique case (r_state)
      PH_IDLE: begin
        if (i_emerg) begin
          w_enterEmerg = 1'b1;
        end else if (w_any) begin
          w_enterGreen = 1'b1;
        end
      end
      PH_GREEN: begin
        if (i_emerg || w_timerDone) begin
          w_nextState = PH_YELLOW;
          w_nextTimer = YELLOW_LOAD;
        end
      end
      PH_YELLOW: begin
        if (w_timerDone) begin
          w_nextState = PH_ALLRED;
          w_nextTimer = ALLRED_LOAD;
        end
      end
      PH_ALLRED: begin
        if (w_timerDone) begin
          if (i_emerg) begin
            w_enterEmerg = 1'b1;
          end else if (w_any) begin
            w_enterGreen = 1'b1;
          end else begin
            w_nextState = PH_IDLE;
          end
        end
      end
      PH_EMERG: begin
        if (!i_emerg) begin
          w_nextState = PH_YELLOW;
          w_nextTimer = YELLOW_LOAD;
        end
      end
      default: w_nextState = PH_IDLE;
    endcase

    // A press for the winner on the entry edge counts as already served
    if (w_enterGreen) begin
      w_nextState   = PH_GREEN;
      w_nextDir     = w_win;
      w_nextPtr     = w_win;
      w_nextPedPend = w_pedSeen & ~dirOneHot(w_win);
      w_nextTimer   = r_pedPend[w_win] ? GREEN_WALK_LOAD : GREEN_LOAD;
      w_nextKeyOut  = KEY_GRN[w_win] | (r_pedPend[w_win] ? KEY_WALK[w_win] : 10'h000);
      w_nextKeyStb  = 1'b1;
    end

    if (w_enterEmerg) begin
      w_nextState  = PH_EMERG;
      w_nextDir    = i_emerg_dir;
      w_nextPtr    = i_emerg_dir;
      w_nextTimer  = '0;
      w_nextKeyOut = KEY_GRN[i_emerg_dir];
      w_nextKeyStb = 1'b1;
    end

    w_nextGrant  = (w_nextState == PH_GREEN || w_nextState == PH_YELLOW ||
                    w_nextState == PH_EMERG) ? dirOneHot(w_nextDir) : 4'b0000;
    w_nextAllRed = (w_nextState == PH_IDLE || w_nextState == PH_ALLRED);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= PH_IDLE;
      r_timer     <= '0;
      r_ptr       <= DIR_S;
      r_servedDir <= DIR_N;
      r_pedPend   <= '0;
      o_key_out   <= '0;
      o_key_stb   <= 1'b0;
      o_grant     <= '0;
      o_all_red   <= 1'b1;
    end else begin
      r_state     <= w_nextState;
      r_timer     <= w_nextTimer;
      r_ptr       <= w_nextPtr;
      r_servedDir <= w_nextDir;
      r_pedPend   <= w_nextPedPend;
      o_key_out   <= w_nextKeyOut;
      o_key_stb   <= w_nextKeyStb;
      o_grant     <= w_nextGrant;
      o_all_red   <= w_nextAllRed;
    end
  end

  assign o_phase    = r_state;
  assign o_ped_pend = r_pedPend;

endmodule
